if_stage: RTL and testbench

//  Fetch stage plus IF/ID pipeline register of the P5 five-stage MIPS core. Holds PC_F, drives the

---
 rtl/if_stage_pkg.sv | 23 ++
 rtl/if_stage_npc_calc.sv | 34 +++
 rtl/if_stage.sv | 82 ++++++++
 tb/tb_if_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the P5 fetch stage: PC-source encodings, reset PC, nop word
// and small address helpers used by the next-PC logic.
package if_stage_pkg;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

   typedef enum logic [1:0] {
      NPC_ADD4   = 2'd0,
      NPC_J      = 2'd1,
      NPC_JR     = 2'd2,
      NPC_BRANCH = 2'd3
   } pcsrc_e;

   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

   function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] idx);
      return {pc[31:28], idx, 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_npc_calc.sv
// Combinational next-PC selection from the D-stage control and compare result.
module npc_calc
   import if_stage_pkg::*;
(
   input  logic [31:0] pc_f_i,
   input  logic [31:0] pc_d_i,
   input  logic [25:0] instr_idx_i,
   input  logic [1:0]  pcsrc_i,
   input  logic        npcsrc_i,
   input  logic        br_taken_i,
   input  logic [31:0] rs_val_i,
   output logic [31:0] npc_o
);

   pcsrc_e      sel;
   logic [31:0] seq_pc;

   assign sel    = pcsrc_e'(pcsrc_i);
   assign seq_pc = pc_f_i + 32'd4;

   // Mismatched PCsrc/NPCsrc pairs fall back to sequential fetch.
   always_comb begin
      npc_o = seq_pc;
      unique case (sel)
         NPC_ADD4:   npc_o = seq_pc;
         NPC_J:      if (npcsrc_i) npc_o = jump_target(pc_d_i, instr_idx_i);
         NPC_JR:     npc_o = rs_val_i;
         NPC_BRANCH: if (!npcsrc_i && br_taken_i)
                        npc_o = pc_d_i + 32'd4 + branch_offset(instr_idx_i[15:0]);
         default:    npc_o = seq_pc;
      endcase
   end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC_F register, instruction-memory addressing and the IF/ID pipeline register.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
   parameter int unsigned IM_AW    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      im_instr,
   output logic [IM_AW-1:0] im_addr,
   output logic [31:0]      pc_f,
   input  logic [1:0]       pcsrc_d,
   input  logic             npcsrc_d,
   input  logic             br_taken_d,
   input  logic [31:0]      rs_val_d,
   output logic [31:0]      instr_d,
   output logic [31:0]      pc_d,
   output logic [31:0]      pc8_d
);

   logic [31:0] pcf_q,  pcf_d;
   logic [31:0] ir_q,   ir_d;
   logic [31:0] pcd_q,  pcd_d;
   logic [31:0] link_q, link_d;
   logic [31:0] npc;
   logic [29:0] word_off;
   logic        in_range;
   logic [31:0] fetch_word;

   npc_calc u_npc_calc (
      .pc_f_i      (pcf_q),
      .pc_d_i      (pcd_q),
      .instr_idx_i (ir_q[25:0]),
      .pcsrc_i     (pcsrc_d),
      .npcsrc_i    (npcsrc_d),
      .br_taken_i  (br_taken_d),
      .rs_val_i    (rs_val_d),
      .npc_o       (npc)
   );

   // Below-base PCs wrap to a huge word offset, so one upper-bits test covers both ends.
   assign word_off   = 30'((pcf_q - PC_RESET) >> 2);
   assign im_addr    = word_off[IM_AW-1:0];
   assign in_range   = ((word_off >> IM_AW) == 30'd0);
   assign fetch_word = in_range ? im_instr : NOP_WORD;

   always_comb begin
      pcf_d  = pcf_q;
      ir_d   = ir_q;
      pcd_d  = pcd_q;
      link_d = link_q;
      if (!stall) begin
         pcf_d  = npc;
         ir_d   = flush ? NOP_WORD : fetch_word;
         pcd_d  = pcf_q;
         link_d = pcf_q + 32'd8;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcf_q  <= PC_RESET;
         ir_q   <= NOP_WORD;
         pcd_q  <= PC_RESET;
         link_q <= PC_RESET + 32'd8;
      end else begin
         pcf_q  <= pcf_d;
         ir_q   <= ir_d;
         pcd_q  <= pcd_d;
         link_q <= link_d;
      end
   end

   assign pc_f    = pcf_q;
   assign instr_d = ir_q;
   assign pc_d    = pcd_q;
   assign pc8_d   = link_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a reference model feeding an expected-value scoreboard.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, flush;
   logic [31:0] im_instr;
   logic [9:0]  im_addr;
   logic [31:0] pc_f;
   logic [1:0]  pcsrc_d;
   logic        npcsrc_d, br_taken_d;
   logic [31:0] rs_val_d;
   logic [31:0] instr_d, pc_d, pc8_d;

   logic [31:0] mem [0:1023];

   typedef struct {
      logic [31:0] pc_f;
      logic [31:0] instr_d;
      logic [31:0] pc_d;
      logic [31:0] pc8_d;
      logic [31:0] im_addr;
   } exp_t;

   exp_t sb [$];
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   logic [31:0] m_pcf, m_ir, m_pcd, m_pc8;

   if_stage #(.PC_RESET(32'h0000_3000), .IM_AW(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .flush      (flush),
      .im_instr   (im_instr),
      .im_addr    (im_addr),
      .pc_f       (pc_f),
      .pcsrc_d    (pcsrc_d),
      .npcsrc_d   (npcsrc_d),
      .br_taken_d (br_taken_d),
      .rs_val_d   (rs_val_d),
      .instr_d    (instr_d),
      .pc_d       (pc_d),
      .pc8_d      (pc8_d)
   );

   always #5 clk = ~clk;
   assign im_instr = mem[im_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_fetch(input logic [31:0] pc);
      logic [31:0] off;
      off = pc - 32'h0000_3000;
      if (off >= 32'd4096) return 32'h0;
      return mem[off[11:2]];
   endfunction

   task automatic model_reset();
      m_pcf = 32'h3000; m_ir = 32'h0; m_pcd = 32'h3000; m_pc8 = 32'h3008;
   endtask

   task automatic push_model();
      exp_t e;
      logic [31:0] off;
      off = (m_pcf - 32'h3000) >> 2;
      e.pc_f = m_pcf; e.instr_d = m_ir; e.pc_d = m_pcd; e.pc8_d = m_pc8;
      e.im_addr = {22'h0, off[9:0]};
      sb.push_back(e);
   endtask

   task automatic compare_pop();
      exp_t e;
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         check("pc_f",    pc_f,            e.pc_f);
         check("instr_d", instr_d,         e.instr_d);
         check("pc_d",    pc_d,            e.pc_d);
         check("pc8_d",   pc8_d,           e.pc8_d);
         check("im_addr", {22'h0, im_addr}, e.im_addr);
      end
   endtask

   task automatic step(input logic st, input logic fl, input logic [1:0] ps,
                       input logic ns, input logic br, input logic [31:0] rs);
      logic [31:0] npc;
      stall = st; flush = fl; pcsrc_d = ps; npcsrc_d = ns; br_taken_d = br; rs_val_d = rs;
      npc = m_pcf + 32'd4;
      if (ps == 2'd1 && ns)
         npc = {m_pcd[31:28], m_ir[25:0], 2'b00};
      else if (ps == 2'd2)
         npc = rs;
      else if (ps == 2'd3 && !ns && br)
         npc = m_pcd + 32'd4 + {{14{m_ir[15]}}, m_ir[15:0], 2'b00};
      if (!st) begin
         m_ir  = fl ? 32'h0 : model_fetch(m_pcf);
         m_pcd = m_pcf;
         m_pc8 = m_pcf + 32'd8;
         m_pcf = npc;
      end
      push_model();
      @(posedge clk);
      #1;
      compare_pop();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h2000_0000 | i;
      mem[2]  = 32'h1000_0003;
      mem[4]  = 32'h0C00_0C10;
      mem[6]  = 32'h1000_0003;
      mem[16] = 32'h1000_FFFF;

      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      pcsrc_d = 2'd0; npcsrc_d = 1'b0; br_taken_d = 1'b0; rs_val_d = 32'h0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      push_model(); compare_pop();
      check("t1_reset_pc8", pc8_d, 32'h3008);

      reset = 1'b1;
      step(0, 0, 2'd0, 0, 0, 0);
      check("t1_pc_f_1", pc_f, 32'h3004);
      check("t1_im_addr_1", {22'h0, im_addr}, 32'd1);
      step(0, 0, 2'd0, 0, 0, 0);
      check("t1_pc_f_2", pc_f, 32'h3008);
      step(0, 0, 2'd0, 0, 0, 0);
      step(0, 0, 2'd3, 0, 1, 0);
      check("t2_taken_target", pc_f, 32'h3018);
      check("t2_slot_in_d", pc_d, 32'h300C);
      step(0, 0, 2'd0, 0, 0, 0);
      step(0, 0, 2'd3, 0, 0, 0);
      check("t2_not_taken", pc_f, 32'h3020);
      step(0, 0, 2'd0, 0, 0, 0);
      step(0, 0, 2'd2, 0, 0, 32'h3010);
      check("t4_jr_target", pc_f, 32'h3010);
      step(0, 0, 2'd0, 0, 0, 0);
      check("t3_jal_in_d", instr_d, 32'h0C00_0C10);
      check("t3_jal_pc8", pc8_d, 32'h3018);
      step(0, 0, 2'd1, 1, 0, 0);
      check("t3_jal_target", pc_f, 32'h3040);
      step(0, 0, 2'd0, 0, 0, 0);
      step(0, 0, 2'd3, 0, 1, 0);
      check("t4_neg_branch", pc_f, 32'h3040);

      step(0, 0, 2'd0, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(1, 0, 2'd3, 0, 1, 0);
      check("t5_stall_pc_f", pc_f, 32'h3044);
      check("t5_stall_instr", instr_d, 32'h1000_FFFF);
      step(1, 1, 2'd3, 0, 1, 0);
      check("t5_stall_flush_instr", instr_d, 32'h1000_FFFF);
      step(0, 0, 2'd3, 0, 1, 0);
      check("t5_after_stall", pc_f, 32'h3040);
      step(0, 1, 2'd0, 0, 0, 0);
      check("t5_flush_nop", instr_d, 32'h0);

      step(0, 0, 2'd1, 0, 0, 0);
      step(0, 0, 2'd3, 1, 1, 0);
      check("inconsistent_add4", pc_f, 32'h304C);
      step(0, 0, 2'd2, 0, 0, 32'h2FFC);
      check("below_base_addr", {22'h0, im_addr}, 32'h3FF);
      step(0, 0, 2'd0, 0, 0, 0);
      check("below_base_nop", instr_d, 32'h0);
      step(0, 0, 2'd2, 0, 0, 32'h4000);
      step(0, 0, 2'd0, 0, 0, 0);
      check("above_depth_nop", instr_d, 32'h0);
      step(0, 0, 2'd2, 0, 0, 32'h3100);
      step(0, 0, 2'd2, 0, 0, 32'hFFFF_FFFC);
      step(0, 0, 2'd0, 0, 0, 0);
      check("wrap_pc_f", pc_f, 32'h0);
      check("wrap_pc8", pc8_d, 32'h4);

      step(0, 0, 2'd2, 0, 0, 32'h3008);
      step(0, 0, 2'd0, 0, 0, 0);
      pcsrc_d = 2'd3; npcsrc_d = 1'b0; br_taken_d = 1'b1;
      #3 reset = 1'b0;
      model_reset();
      #1;
      push_model(); compare_pop();
      check("t6_async_pc_f", pc_f, 32'h3000);
      @(posedge clk); #1;
      push_model(); compare_pop();
      reset = 1'b1;
      step(0, 0, 2'd0, 0, 0, 0);
      check("t6_resume_pc_d", pc_d, 32'h3000);
      check("t6_resume_pc_f", pc_f, 32'h3004);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
